// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised pins, per-bit edge capture, maskable level irq.
// Optional per-bit debounce is enabled by defining PIO_DEBOUNCE_EN.
module pio_in_edge_irq #(
  parameter int WIDTH        = 18,
  parameter int SYNC_STAGES  = 2,
  parameter int EDGE_TYPE    = 0,
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("pio_in_edge_irq: WIDTH must be in 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pio_in_edge_irq: SYNC_STAGES must be in 2..4");
  end
  if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
    $error("pio_in_edge_irq: EDGE_TYPE must be 0, 1 or 2");
  end
  if (DEBOUNCE_CNT < 1) begin : g_bad_dbc
    $error("pio_in_edge_irq: DEBOUNCE_CNT must be at least 1");
  end

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_data_q;
  logic [WIDTH-1:0] r_prev_q;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused;

  assign w_unused = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end
  assign w_sync_q = r_sync[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_data_q;

  // A bit only follows sync_q after DEBOUNCE_CNT consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_q <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync_q[i] == r_data_q[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CNT - 1)) begin
          r_data_q[i] <= w_sync_q[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end
  assign w_data_q = r_data_q;
`else
  assign w_data_q = w_sync_q;
`endif

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = w_data_q & ~r_prev_q;
      1:       w_edge = ~w_data_q & r_prev_q;
      default: w_edge = w_data_q ^ r_prev_q;
    endcase
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // New edges are OR-ed in after the clear so a coincident edge survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_q  <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
      readdata  <= '0;
    end else begin
      r_prev_q  <= w_data_q;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
      case (address)
        2'd0:    readdata <= 32'(w_data_q);
        2'd2:    readdata <= 32'(r_irqmask);
        2'd3:    readdata <= 32'(r_edgecap);
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: one rising-edge and one any-edge instance on shared stimulus.
module tb_pio_in_edge_irq;
  localparam int W = 18;
`ifdef PIO_DEBOUNCE_EN
  localparam int LAT = 2 + 8;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata_r, readdata_a;
  logic          irq_r, irq_a;
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   vr, va;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CNT(8)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_r), .irq(irq_r));

  pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEBOUNCE_CNT(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick(1);
    vr = readdata_r;
    va = readdata_a;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    tick(3);
    chk("reset_readdata", readdata_r, 32'h0);
    chk("reset_irq_r", {31'b0, irq_r}, 32'h0);
    chk("reset_irq_a", {31'b0, irq_a}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    rd(2'd0); chk("rst_data", vr, 32'h0);
    rd(2'd2); chk("rst_mask", vr, 32'h0);
    rd(2'd3); chk("rst_edge", vr, 32'h0);

    // Pattern read with exact latency: readdata lags data_q by one clock.
    address = 2'd0;
    in_port = 18'h2A5F5;
    tick(LAT - 1);
    rd(2'd0); chk("data_before", vr, 32'h0);
    rd(2'd0); chk("data_after", vr, 32'h0002A5F5);
    rd(2'd3); chk("edge_rise_r", vr, 32'h0002A5F5);
    chk("edge_rise_a", va, 32'h0002A5F5);
    chk("irq_masked", {31'b0, irq_r | irq_a}, 32'h0);
    wr(2'd0, 32'hFFFFFFFF);
    rd(2'd0); chk("data_wr_ignored", vr, 32'h0002A5F5);
    rd(2'd1); chk("addr1_zero", vr, 32'h0);
    wr(2'd3, 32'h0003FFFF);
    rd(2'd3); chk("edge_cleared", vr, 32'h0);

    // Falling edges: only the any-edge instance captures.
    in_port = 18'h0;
    tick(LAT + 2);
    rd(2'd3); chk("fall_r", vr, 32'h0);
    chk("fall_a", va, 32'h0002A5F5);
    wr(2'd3, 32'h0003FFFF);

    wr(2'd2, 32'h1);
    chk("irq_idle", {31'b0, irq_r}, 32'h0);
    in_port = 18'h1;
    tick(LAT + 1);
    chk("irq_bit0_r", {31'b0, irq_r}, 32'h1);
    chk("irq_bit0_a", {31'b0, irq_a}, 32'h1);
    rd(2'd3); chk("edge_bit0", vr, 32'h1);
    wr(2'd3, 32'h1);
    chk("irq_cleared", {31'b0, irq_r}, 32'h0);
    rd(2'd3); chk("edge_bit0_clr", vr, 32'h0);

    // Bit3 edge coincident with a clear of bit3.
    in_port = 18'h9;
    tick(LAT + 1);
    in_port = 18'h1;
    tick(LAT + 1);
    rd(2'd3); chk("bit3_pre", vr, 32'h8);
    in_port = 18'h9;
    tick(LAT);
    wr(2'd3, 32'h8);
    rd(2'd3); chk("bit3_set_wins_r", vr, 32'h8);
    chk("bit3_set_wins_a", va, 32'h8);
    wr(2'd3, 32'h8);
    rd(2'd3); chk("bit3_clr_alone", vr, 32'h0);

    // Capture with mask off, then unmask.
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h0003FFFF);
    in_port = 18'h29;
    tick(LAT + 1);
    in_port = 18'h09;
    tick(LAT + 1);
    rd(2'd3); chk("bit5_edge_a", va, 32'h20);
    chk("bit5_edge_r", vr, 32'h20);
    chk("bit5_irq_off", {31'b0, irq_a}, 32'h0);
    wr(2'd2, 32'h20);
    chk("bit5_irq_on_a", {31'b0, irq_a}, 32'h1);
    chk("bit5_irq_on_r", {31'b0, irq_r}, 32'h1);
    rd(2'd2); chk("mask_read", vr, 32'h20);
    wr(2'd2, 32'hFFFFFFFF);
    rd(2'd2); chk("mask_width", vr, 32'h0003FFFF);

    // Asynchronous reset in mid-cycle.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_irq", {31'b0, irq_a}, 32'h0);
    chk("arst_readdata", readdata_r, 32'h0);
    in_port = 18'h0;
    tick(2);
    reset_n = 1'b1;
    rd(2'd3); chk("arst_edge", vr, 32'h0);
    rd(2'd2); chk("arst_mask", vr, 32'h0);

`ifdef PIO_DEBOUNCE_EN
    tick(LAT + 2);
    in_port = 18'h1;
    tick(5);
    in_port = 18'h0;
    tick(20);
    rd(2'd0); chk("glitch_data", vr, 32'h0);
    rd(2'd3); chk("glitch_edge", va, 32'h0);
    in_port = 18'h1;
    address = 2'd0;
    tick(LAT - 1);
    rd(2'd0); chk("dbc_before", vr, 32'h0);
    rd(2'd0); chk("dbc_after", vr, 32'h1);
    tick(2);
    in_port = 18'h0;
    tick(LAT + 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
